// File: rtl/kvs_cmd_arbiter_pkg.sv
// Shared types and widths for the two-lane KVS command arbiter and its kernel interface.
package kvs_cmd_arbiter_pkg;

    localparam int KEY_W   = 128;
    localparam int VAL_W   = 32;
    localparam int ADDR_W  = 16;
    localparam int NUM_REQ = 2;
    localparam int OP_W    = 3;
    localparam int NUM_OPS = 5;

    typedef enum logic [OP_W-1:0] {
        OP_SEARCH = 3'd0,
        OP_UPDATE = 3'd1,
        OP_WRITE  = 3'd2,
        OP_ERASE  = 3'd3,
        OP_READ   = 3'd4
    } kvs_op_e;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_WAIT_RDY,
        ST_RUN,
        ST_DRAIN
    } kvs_state_e;

    function automatic logic op_is_valid(input logic [OP_W-1:0] op);
        return op <= OP_W'(OP_READ);
    endfunction

endpackage

// File: rtl/kvs_cmd_arbiter_tag.sv
// In-order tag FIFO: remembers which requester owns each command still pending in the kernel.
module kvs_tag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         push_i,
    input  logic                         din_i,
    input  logic                         pop_i,
    output logic                         dout_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/kvs_cmd_arbiter.sv
// Round-robin arbiter feeding two requester lanes into one KVS kernel, routing in-order acks back.
module kvs_cmd_arbiter
    import kvs_cmd_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*OP_W-1:0]    req_cmd,
    input  logic [NUM_REQ*KEY_W-1:0]   req_key,
    input  logic [NUM_REQ*VAL_W-1:0]   req_value,
    input  logic                       drain,
    output logic                       drained,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic                       rsp_hit,
    output logic [ADDR_W-1:0]          rsp_addr,
    output logic [VAL_W-1:0]           rsp_value,
    output logic                       err,
    output logic                       I_CMD_INIT,
    output logic                       I_CMD_VALID,
    output logic                       I_CMD_SEARCH,
    output logic                       I_CMD_UPDATE,
    output logic                       I_CMD_WRITE,
    output logic                       I_CMD_ERASE,
    output logic                       I_CMD_READ,
    output logic [KEY_W-1:0]           I_KEY_DAT,
    output logic [VAL_W-1:0]           I_KEY_VALUE,
    input  logic                       O_READY,
    input  logic                       O_WAIT,
    input  logic                       O_CMD_FULL,
    input  logic                       O_ACK,
    input  logic                       O_SINGLE_HIT,
    input  logic                       O_MULTI_HIT,
    input  logic [ADDR_W-1:0]          O_ENT_ADDR,
    input  logic [VAL_W-1:0]           O_KEY_VALUE
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    kvs_state_e           state_q, state_d;
    logic                 prio_q;
    logic                 grant_en, init_set;
    logic [NUM_REQ-1:0]   gnt;
    logic                 accept, acc_id, push, bad_op;
    logic [OP_W-1:0]      sel_cmd;
    logic [OP_W-1:0]      lane_cmd [NUM_REQ];
    logic [KEY_W-1:0]     lane_key [NUM_REQ];
    logic [VAL_W-1:0]     lane_val [NUM_REQ];
    logic [NUM_OPS-1:0]   op_strb_d, op_strb_q;
    logic                 init_q, cmd_valid_q;
    logic [KEY_W-1:0]     key_q;
    logic [VAL_W-1:0]     val_q;
    logic [NUM_REQ-1:0]   rsp_valid_q;
    logic                 rsp_hit_q, err_q;
    logic [ADDR_W-1:0]    rsp_addr_q;
    logic [VAL_W-1:0]     rsp_value_q;
    logic                 fifo_full, fifo_empty, fifo_dout, pop, spurious;
    logic [CNT_W-1:0]     fifo_count;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
        assign lane_cmd[gi] = req_cmd[gi*OP_W +: OP_W];
        assign lane_key[gi] = req_key[gi*KEY_W +: KEY_W];
        assign lane_val[gi] = req_value[gi*VAL_W +: VAL_W];
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_INIT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT:     state_d = ST_WAIT_RDY;
            ST_WAIT_RDY: if (O_READY) state_d = ST_RUN;
            ST_RUN:      if (drain)   state_d = ST_DRAIN;
            ST_DRAIN:    if (!drain)  state_d = ST_RUN;
            default:     state_d = ST_INIT;
        endcase
    end

    // Drain is sampled by the FSM only, so a request granted in the cycle drain rises still issues.
    always_comb begin
        init_set = (state_q == ST_INIT);
        grant_en = !reset && (state_q == ST_RUN) && O_READY && !O_WAIT
                   && !O_CMD_FULL && !fifo_full;
        drained  = !reset && drain && (fifo_count == '0);
    end

    always_comb begin
        gnt = '0;
        if (grant_en) begin
            if (req_valid[0] && (!req_valid[1] || !prio_q)) gnt[0] = 1'b1;
            else if (req_valid[1])                          gnt[1] = 1'b1;
        end
    end

    assign req_ready = gnt;
    assign accept    = |gnt;
    assign acc_id    = gnt[1];
    assign sel_cmd   = lane_cmd[acc_id];
    // Undefined opcodes are consumed and flagged, never forwarded or tagged.
    assign push      = accept && op_is_valid(sel_cmd);
    assign bad_op    = accept && !op_is_valid(sel_cmd);
    assign pop       = O_ACK && !fifo_empty;
    assign spurious  = O_ACK && fifo_empty;

    for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_op
        assign op_strb_d[gi] = push && (sel_cmd == OP_W'(gi));
    end

    kvs_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk     (clk),
        .srst    (reset),
        .push_i  (push),
        .din_i   (acc_id),
        .pop_i   (pop),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q      <= 1'b0;
            init_q      <= 1'b0;
            cmd_valid_q <= 1'b0;
            op_strb_q   <= '0;
            key_q       <= '0;
            val_q       <= '0;
            rsp_valid_q <= '0;
            rsp_hit_q   <= 1'b0;
            rsp_addr_q  <= '0;
            rsp_value_q <= '0;
            err_q       <= 1'b0;
        end else begin
            if (accept) prio_q <= ~acc_id;
            init_q      <= init_set;
            cmd_valid_q <= push;
            op_strb_q   <= op_strb_d;
            key_q       <= push ? lane_key[acc_id] : '0;
            val_q       <= push ? lane_val[acc_id] : '0;
            rsp_valid_q <= '0;
            if (pop) begin
                rsp_valid_q[fifo_dout] <= 1'b1;
                rsp_hit_q              <= O_SINGLE_HIT | O_MULTI_HIT;
                rsp_addr_q             <= O_ENT_ADDR;
                rsp_value_q            <= O_KEY_VALUE;
            end
            if (spurious || bad_op) err_q <= 1'b1;
        end
    end

    assign I_CMD_INIT   = init_q;
    assign I_CMD_VALID  = cmd_valid_q;
    assign I_CMD_SEARCH = op_strb_q[OP_SEARCH];
    assign I_CMD_UPDATE = op_strb_q[OP_UPDATE];
    assign I_CMD_WRITE  = op_strb_q[OP_WRITE];
    assign I_CMD_ERASE  = op_strb_q[OP_ERASE];
    assign I_CMD_READ   = op_strb_q[OP_READ];
    assign I_KEY_DAT    = key_q;
    assign I_KEY_VALUE  = val_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_hit      = rsp_hit_q;
    assign rsp_addr     = rsp_addr_q;
    assign rsp_value    = rsp_value_q;
    assign err          = err_q;

endmodule

// File: tb/tb_kvs_cmd_arbiter.sv
// Directed bench for kvs_cmd_arbiter: init sequence, round-robin, response routing, capacity, drain, errors.
module tb_kvs_cmd_arbiter;
    import kvs_cmd_arbiter_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   req_valid, req_ready;
    logic [5:0]   req_cmd;
    logic [255:0] req_key;
    logic [63:0]  req_value;
    logic         drain, drained;
    logic [1:0]   rsp_valid;
    logic         rsp_hit;
    logic [15:0]  rsp_addr;
    logic [31:0]  rsp_value;
    logic         err;
    logic         I_CMD_INIT, I_CMD_VALID, I_CMD_SEARCH, I_CMD_UPDATE, I_CMD_WRITE, I_CMD_ERASE, I_CMD_READ;
    logic [127:0] I_KEY_DAT;
    logic [31:0]  I_KEY_VALUE;
    logic         O_READY, O_WAIT, O_CMD_FULL, O_ACK, O_SINGLE_HIT, O_MULTI_HIT;
    logic [15:0]  O_ENT_ADDR;
    logic [31:0]  O_KEY_VALUE;

    int n_checks = 0;
    int n_pass   = 0;
    logic [1:0] exp_gnt [8];

    always #5 clk = ~clk;

    kvs_cmd_arbiter #(.MAX_OUTSTANDING(16)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_cmd(req_cmd),
        .req_key(req_key), .req_value(req_value),
        .drain(drain), .drained(drained),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_addr(rsp_addr), .rsp_value(rsp_value),
        .err(err),
        .I_CMD_INIT(I_CMD_INIT), .I_CMD_VALID(I_CMD_VALID), .I_CMD_SEARCH(I_CMD_SEARCH),
        .I_CMD_UPDATE(I_CMD_UPDATE), .I_CMD_WRITE(I_CMD_WRITE), .I_CMD_ERASE(I_CMD_ERASE),
        .I_CMD_READ(I_CMD_READ), .I_KEY_DAT(I_KEY_DAT), .I_KEY_VALUE(I_KEY_VALUE),
        .O_READY(O_READY), .O_WAIT(O_WAIT), .O_CMD_FULL(O_CMD_FULL), .O_ACK(O_ACK),
        .O_SINGLE_HIT(O_SINGLE_HIT), .O_MULTI_HIT(O_MULTI_HIT),
        .O_ENT_ADDR(O_ENT_ADDR), .O_KEY_VALUE(O_KEY_VALUE)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_lane(input int l, input logic [2:0] op, input logic [127:0] key, input logic [31:0] val);
        req_cmd[l*3 +: 3]       = op;
        req_key[l*128 +: 128]   = key;
        req_value[l*32 +: 32]   = val;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        reset = 1'b1; req_valid = 2'b01; req_cmd = '0; req_key = '0; req_value = '0; drain = 1'b1;
        O_READY = 1'b0; O_WAIT = 1'b0; O_CMD_FULL = 1'b0; O_ACK = 1'b0;
        O_SINGLE_HIT = 1'b0; O_MULTI_HIT = 1'b0; O_ENT_ADDR = '0; O_KEY_VALUE = '0;

        // Reset values and init sequence
        repeat (3) tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_init", I_CMD_INIT, 0);
        chk("rst_cmd_valid", I_CMD_VALID, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_drained", drained, 0);
        chk("rst_key", I_KEY_DAT, 0);
        reset = 1'b0; drain = 1'b0; settle();
        chk("init_ready", req_ready, 0);
        chk("init_pre", I_CMD_INIT, 0);
        tick();
        chk("init_pulse", I_CMD_INIT, 1);
        chk("wait_ready", req_ready, 0);
        tick();
        chk("init_end", I_CMD_INIT, 0);
        O_READY = 1'b1; settle();
        chk("wait_ready2", req_ready, 0);
        tick();
        chk("run_ready", req_ready, 2'b01);
        req_valid = 2'b00;

        // Kernel stall inputs, then round-robin with both lanes valid
        set_lane(0, OP_SEARCH, 128'hA0, 32'h10);
        set_lane(1, OP_UPDATE, 128'hB1, 32'h11);
        req_valid = 2'b11;
        O_WAIT = 1'b1; settle();
        chk("o_wait_block", req_ready, 0);
        O_WAIT = 1'b0; O_CMD_FULL = 1'b1; settle();
        chk("cmd_full_block", req_ready, 0);
        O_CMD_FULL = 1'b0; settle();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rr_ready%0d", i), req_ready, exp_gnt[i]);
            tick();
            $display("issue %0d: lane_mask=%b key=0x%0h", i, exp_gnt[i], I_KEY_DAT);
            chk($sformatf("rr_key%0d", i), I_KEY_DAT, (exp_gnt[i] == 2'b01) ? 128'hA0 : 128'hB1);
            chk($sformatf("rr_upd%0d", i), I_CMD_UPDATE, (exp_gnt[i] == 2'b10) ? 1 : 0);
        end
        req_valid = 2'b00;
        for (int i = 0; i < 8; i++) begin
            O_ACK = 1'b1; O_ENT_ADDR = 16'(i);
            tick();
            $display("response %0d: rsp_valid=%b addr=%0d", i, rsp_valid, rsp_addr);
            chk($sformatf("rr_rsp%0d", i), rsp_valid, exp_gnt[i]);
            chk($sformatf("rr_addr%0d", i), rsp_addr, 16'(i));
        end
        O_ACK = 1'b0;
        tick();
        chk("rsp_idle", rsp_valid, 0);

        // Single SEARCH with hit
        set_lane(0, OP_SEARCH, 128'h1234, 32'h0);
        req_valid = 2'b01; settle();
        chk("srch_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("srch_valid", I_CMD_VALID, 1);
        chk("srch_strobe", I_CMD_SEARCH, 1);
        chk("srch_no_write", I_CMD_WRITE, 0);
        chk("srch_key", I_KEY_DAT, 128'h1234);
        tick();
        chk("srch_valid_end", I_CMD_VALID, 0);
        O_ACK = 1'b1; O_SINGLE_HIT = 1'b1; O_ENT_ADDR = 16'h0007; O_KEY_VALUE = 32'd5;
        tick();
        O_ACK = 1'b0; O_SINGLE_HIT = 1'b0;
        $display("search response: rsp_valid=%b hit=%b addr=%0d value=%0d", rsp_valid, rsp_hit, rsp_addr, rsp_value);
        chk("srch_rsp_valid", rsp_valid, 2'b01);
        chk("srch_rsp_hit", rsp_hit, 1);
        chk("srch_rsp_addr", rsp_addr, 7);
        chk("srch_rsp_value", rsp_value, 5);
        tick();
        chk("srch_rsp_end", rsp_valid, 0);

        // Outstanding limit of 16
        set_lane(0, OP_WRITE, 128'hC0, 32'h20);
        req_valid = 2'b01; settle();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("cap_ready%0d", i), req_ready, 2'b01);
            tick();
        end
        chk("cap_write", I_CMD_WRITE, 1);
        chk("cap_full", req_ready, 0);
        tick();
        chk("cap_hold", req_ready, 0);
        O_ACK = 1'b1; O_ENT_ADDR = 16'h0; settle();
        chk("cap_ack_cycle", req_ready, 0);
        tick();
        chk("cap_17th", req_ready, 2'b01);
        chk("cap_first_rsp", rsp_valid, 2'b01);
        tick();
        O_ACK = 1'b0;
        chk("cap_after_both", req_ready, 2'b01);
        tick();
        chk("cap_refull", req_ready, 0);
        req_valid = 2'b00;
        O_ACK = 1'b1;
        repeat (16) tick();
        O_ACK = 1'b0;
        tick();
        chk("cap_no_err", err, 0);

        // Drain
        set_lane(0, OP_READ, 128'hD0, 32'h0);
        req_valid = 2'b01; settle();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drn_ready%0d", i), req_ready, 2'b01);
            tick();
        end
        drain = 1'b1; settle();
        chk("drain_rise_ready", req_ready, 2'b01);
        chk("drain_rise_drained", drained, 0);
        tick();
        chk("drain_issue", I_CMD_READ, 1);
        chk("drain_block", req_ready, 0);
        for (int i = 0; i < 4; i++) begin
            O_ACK = 1'b1; settle();
            chk($sformatf("drain_pend%0d", i), drained, 0);
            tick();
        end
        O_ACK = 1'b0; settle();
        chk("drained_up", drained, 1);
        chk("drain_still_block", req_ready, 0);
        drain = 1'b0; settle();
        chk("drained_down", drained, 0);
        chk("drain_exit_hold", req_ready, 0);
        tick();
        chk("resume_ready", req_ready, 2'b01);
        req_valid = 2'b00;

        // Spurious ack
        O_ACK = 1'b1;
        tick();
        O_ACK = 1'b0;
        chk("spur_err", err, 1);
        chk("spur_rsp", rsp_valid, 0);
        repeat (3) tick();
        chk("err_sticky", err, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("err_cleared", err, 0);

        // Reset with a command in flight, then a late ack
        tick();
        tick();
        req_valid = 2'b01; settle();
        chk("mid_ready", req_ready, 2'b01);
        tick();
        reset = 1'b1; settle();
        chk("mid_rst_ready", req_ready, 0);
        tick();
        chk("mid_rst_cmd", I_CMD_VALID, 0);
        reset = 1'b0; req_valid = 2'b00;
        O_ACK = 1'b1;
        tick();
        O_ACK = 1'b0;
        chk("late_ack_err", err, 1);
        chk("late_ack_rsp", rsp_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
